// File: rtl/botoes_pkg.sv
// Shared definitions for the pushbutton input path: FSM state codes and button helpers.
package botoes_pkg;

  localparam int NUM_BOTOES = 4;

  // Codes double as the db_estado value shown on the debug display.
  typedef enum logic [3:0] {
    OCIOSO    = 4'h0,
    DEB_PRESS = 4'h1,
    SEGURANDO = 4'h2,
    DEB_SOLTA = 4'h3
  } estado_t;

  function automatic logic ehOneHot(input logic [NUM_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - NUM_BOTOES'(1))) == '0);
  endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for asynchronous inputs, parameterized width.
module sincronizador #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] entrada,
  output logic [WIDTH-1:0] saida
);

  logic [WIDTH-1:0] estagio1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estagio1 <= '0;
      saida    <= '0;
    end else begin
      estagio1 <= entrada;
      saida    <= estagio1;
    end
  end

endmodule

// File: rtl/botoes_jogada_encoder.sv
// Debounces the four player buttons and turns each accepted press into a
// registered one-hot play code with a single-cycle jogada (or invalida) strobe.
module botoes_jogada_encoder
  import botoes_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  zera,
  input  logic [NUM_BOTOES-1:0] botoes_in,
  output logic [NUM_BOTOES-1:0] botoes,
  output logic                  jogada,
  output logic                  invalida,
  output logic [3:0]            db_estado
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BOTOES-1:0] amostra;
  logic [NUM_BOTOES-1:0] candidato;
  logic [CNT_W-1:0]      contador;
  estado_t               estado;

  sincronizador #(.WIDTH(NUM_BOTOES)) u_sincronizador (
    .clock   (clock),
    .reset   (reset),
    .entrada (botoes_in),
    .saida   (amostra)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= OCIOSO;
      contador  <= '0;
      candidato <= '0;
      botoes    <= '0;
      jogada    <= 1'b0;
      invalida  <= 1'b0;
    end else begin
      jogada   <= 1'b0;
      invalida <= 1'b0;
      // A load in the FSM below overrides this clear when both happen together.
      if (zera) botoes <= '0;
      case (estado)
        OCIOSO: begin
          if (amostra != '0) begin
            candidato <= amostra;
            contador  <= '0;
            estado    <= DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (amostra == '0) begin
            estado <= OCIOSO;
          end else if (amostra != candidato) begin
            candidato <= amostra;
            contador  <= '0;
          end else if (contador == ULTIMO) begin
            estado <= SEGURANDO;
            if (!ehOneHot(candidato)) begin
              invalida <= 1'b1;
            end else if (enable) begin
              botoes <= candidato;
              jogada <= 1'b1;
            end
          end else begin
            contador <= contador + CNT_W'(1);
          end
        end
        SEGURANDO: begin
          if (amostra == '0) begin
            contador <= '0;
            estado   <= DEB_SOLTA;
          end
        end
        DEB_SOLTA: begin
          if (amostra != '0) begin
            estado <= SEGURANDO;
          end else if (contador == ULTIMO) begin
            estado <= OCIOSO;
          end else begin
            contador <= contador + CNT_W'(1);
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_botoes_jogada_encoder.sv
// Scoreboard bench: a run-length reference model predicts strobes and play codes.
module tb_botoes_jogada_encoder;

  localparam int D = 4;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       zera;
  logic [3:0] botoes_in;
  logic [3:0] botoes;
  logic       jogada;
  logic       invalida;
  logic [3:0] db_estado;

  int compared   = 0;
  int mismatched = 0;
  int edgeCnt    = 0;

  botoes_jogada_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .zera      (zera),
    .botoes_in (botoes_in),
    .botoes    (botoes),
    .jogada    (jogada),
    .invalida  (invalida),
    .db_estado (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) edgeCnt <= edgeCnt + 1;

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, act, exp, $time);
    end
  endtask

  // Reference model: a press is accepted once the synchronized sample shows the same
  // nonzero pattern D+1 times in a row; re-arming needs D+1 consecutive zero samples.
  typedef struct {
    bit         ehJogada;
    logic [3:0] cod;
  } ev_t;

  ev_t        fila[$];
  logic [3:0] m1, m2, amostraRef, runVal, botoesRef;
  int         runLen, zeroLen;
  bit         armed;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m1 = 0; m2 = 0; runVal = 0; runLen = 0; zeroLen = 0;
      armed = 1; botoesRef = 0;
      fila.delete();
    end else begin
      amostraRef = m2;
      m2 = m1;
      m1 = botoes_in;
      if (zera) botoesRef = 0;
      if (amostraRef == 0) begin
        runLen = 0;
        zeroLen++;
        if (!armed && zeroLen >= D + 1) armed = 1;
      end else begin
        zeroLen = 0;
        if (runLen > 0 && amostraRef == runVal) runLen++;
        else begin
          runVal = amostraRef;
          runLen = 1;
        end
        if (armed && runLen == D + 1) begin
          armed = 0;
          if ($countones(amostraRef) == 1) begin
            if (enable) begin
              botoesRef = amostraRef;
              fila.push_back('{1'b1, amostraRef});
            end
          end else begin
            fila.push_back('{1'b0, botoesRef});
          end
        end
      end
    end
  end

  // Monitor
  bit         gravando = 0;
  logic [3:0] ultimoEstado;
  logic [3:0] seqEstado[$];

  always @(negedge clock) begin
    if (reset) begin
      ev_t e;
      check("botoes", botoes, botoesRef);
      check("strobes exclusivos", jogada & invalida, 0);
      if (fila.size() > 0) begin
        e = fila.pop_front();
        check("jogada", jogada, e.ehJogada);
        check("invalida", invalida, !e.ehJogada);
        check("botoes no strobe", botoes, e.cod);
      end else begin
        check("strobe inesperado", {jogada, invalida}, 0);
      end
      if (gravando && db_estado != ultimoEstado) begin
        seqEstado.push_back(db_estado);
        ultimoEstado = db_estado;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    botoes_in = v;
    step(n);
  endtask

  // Drives v and requires jogada exactly D+3 edges after the drive point.
  task automatic pressLatency(input logic [3:0] v, input string nome);
    int  n;
    bit  seen;
    int  lat;
    seen = 0;
    lat  = -1;
    botoes_in = v;
    n = edgeCnt;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (jogada) begin
        seen = 1;
        lat = edgeCnt - n;
      end
    end
    #1;
    check(nome, lat, D + 3);
  endtask

  initial begin
    logic [3:0] esperado[5];
    logic [3:0] v;
    esperado = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h0};
    reset = 1'b0; enable = 1'b1; zera = 1'b0; botoes_in = 4'h0;
    step(3);
    check("reset botoes", botoes, 0);
    check("reset jogada", jogada, 0);
    check("reset invalida", invalida, 0);
    check("reset db_estado", db_estado, 0);
    reset = 1'b1;
    step(3);

    // 1: clean press with state trace
    ultimoEstado = db_estado;
    seqEstado.push_back(db_estado);
    gravando = 1;
    pressLatency(4'b0100, "latencia press limpo");
    hold(4'b0100, 13);
    hold(4'b0000, 12);
    gravando = 0;
    check("seq estados tamanho", seqEstado.size(), 5);
    for (int i = 0; i < 5 && i < seqEstado.size(); i++)
      check("seq estados", seqEstado[i], esperado[i]);

    // 2: bouncing press and release
    for (int i = 0; i < 5; i++) begin
      hold(4'b0010, 2);
      hold(4'b0000, 2);
    end
    hold(4'b0010, 12);
    for (int i = 0; i < 4; i++) begin
      hold(4'b0000, 2);
      hold(4'b0010, 2);
    end
    hold(4'b0000, 12);

    // 3: multi-button press keeps previous code
    hold(4'b0001, 10);
    hold(4'b0000, 10);
    hold(4'b1001, 10);
    hold(4'b0000, 10);
    check("botoes apos invalida", botoes, 4'b0001);

    // 4: enable low at acceptance blocks the play until a fresh press
    enable = 1'b0;
    hold(4'b1000, 10);
    enable = 1'b1;
    hold(4'b1000, 5);
    check("sem jogada com enable baixo", botoes, 4'b0001);
    hold(4'b0000, 10);
    hold(4'b1000, 10);
    hold(4'b0000, 10);
    check("botoes apos nova press", botoes, 4'b1000);

    // 5: zera against a load, then alone
    botoes_in = 4'b0010;
    step(6);
    zera = 1'b1;
    step(1);
    zera = 1'b0;
    check("load vence zera", botoes, 4'b0010);
    zera = 1'b1;
    step(1);
    zera = 1'b0;
    check("zera limpa", botoes, 4'h0);
    hold(4'b0010, 5);
    hold(4'b0000, 10);

    // 6: asynchronous reset mid-debounce, then press held through release of reset
    hold(4'b0001, 10);
    hold(4'b0000, 10);
    botoes_in = 4'b0001;
    step(5);
    check("estado antes do reset", db_estado, 4'h1);
    reset = 1'b0;
    #1;
    check("reset async botoes", botoes, 0);
    check("reset async jogada", jogada, 0);
    check("reset async invalida", invalida, 0);
    check("reset async db_estado", db_estado, 0);
    step(2);
    reset = 1'b1;
    pressLatency(4'b0001, "latencia apos reset");
    hold(4'b0001, 5);
    hold(4'b0000, 10);

    // Randomized segments
    for (int s = 0; s < 300; s++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) v = 4'h0;
      else if (r < 8) v = 4'b0001 << $urandom_range(0, 3);
      else v = 4'($urandom_range(1, 15));
      enable = ($urandom_range(0, 4) != 0);
      botoes_in = v;
      for (int c = $urandom_range(1, 3 * D); c > 0; c--) begin
        zera = ($urandom_range(0, 19) == 0);
        step(1);
      end
      zera = 1'b0;
    end
    hold(4'h0, 20);
    check("fila vazia", fila.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
